// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed register-array memory.
// One transaction at a time; all handshake outputs are registered and follow the FSM state.
module axi_lite_mem_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int SHIFT  = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int IDX_W  = ADDR_WIDTH - SHIFT;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One spare bit so MEM_DEPTH itself is representable in the range compare.
  localparam int CMP_W  = ((IDX_W > MEM_AW) ? IDX_W : MEM_AW) + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  function automatic logic [CMP_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] shifted;
    shifted    = addr >> SHIFT;
    word_index = CMP_W'(shifted);
  endfunction

  function automatic logic index_in_range(input logic [CMP_W-1:0] idx);
    index_in_range = (idx < CMP_W'(MEM_DEPTH));
  endfunction

  state_t                state_r;
  logic                  arready_r;
  logic                  awready_r;
  logic                  wready_r;
  logic                  rvalid_r;
  logic                  bvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic [1:0]            bresp_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [CMP_W-1:0]      ar_idx_s;
  logic [CMP_W-1:0]      aw_idx_s;
  logic                  ar_ok_s;
  logic                  aw_ok_s;
  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // The read address is consumed at its handshake; only the write address must be held for W.
  assign ar_idx_s  = word_index(araddr);
  assign aw_idx_s  = word_index(awaddr_r);
  assign ar_ok_s   = index_in_range(ar_idx_s);
  assign aw_ok_s   = index_in_range(aw_idx_s);
  assign rd_word_s = mem[ar_idx_s[MEM_AW-1:0]];
  assign mem_we_s  = (state_r == WDATA) && wready_r && wvalid && aw_ok_s;

  // Byte-lane memory write at the W handshake; contents deliberately survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) begin
          mem[aw_idx_s[MEM_AW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered Moore handshake outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= IDLE;
      arready_r <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
      bresp_r   <= RESP_OKAY;
      awaddr_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arvalid) begin
            state_r   <= RADDR;
            arready_r <= 1'b1;
          end else if (awvalid) begin
            state_r   <= WADDR;
            awready_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
          end
        end
        RADDR: begin
          if (arvalid && arready_r) begin
            rdata_r   <= ar_ok_s ? rd_word_s : '0;
            rresp_r   <= ar_ok_s ? RESP_OKAY : RESP_SLVERR;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            state_r   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid_r && rready) begin
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        WADDR: begin
          if (awvalid && awready_r) begin
            awaddr_r  <= awaddr;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            state_r   <= WDATA;
          end
        end
        WDATA: begin
          if (wvalid && wready_r) begin
            bresp_r  <= aw_ok_s ? RESP_OKAY : RESP_SLVERR;
            wready_r <= 1'b0;
            bvalid_r <= 1'b1;
            state_r  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid_r && bready) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          arready_r <= 1'b0;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          rvalid_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign arready = arready_r;
  assign awready = awready_r;
  assign wready  = wready_r;
  assign rvalid  = rvalid_r;
  assign bvalid  = bvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign bresp   = bresp_r;

endmodule
